shared_bus_rr: RTL and testbench

Parametrised shared-bus interconnect that replaces the fixed 4-master/8-slave bus used in the processor top level. It arbitrates NUM_MASTERS masters round-robin, with ownership held for as long as the owner requests. It decodes the owner's word address into NUM_SLAVES chip selects and returns the selected slave's read data and ready to all masters. It also adds what the previous bus lacked: an error response for unmapped addresses, a bus-timeout watchdog, and error reporting.

---
 rtl/shared_bus_rr_if.sv | 45 ++++
 rtl/shared_bus_rr.sv | 200 ++++++++++++++++++++
 tb/tb_shared_bus_rr.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/shared_bus_rr_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shared_bus_rr_if                                                         |
// | Master-side and slave-side signal bundle of the shared round-robin bus.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface shared_bus_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 8,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_req_;
    logic [NUM_MASTERS-1:0]        m_grnt_;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS-1:0]        m_as_;
    logic [NUM_MASTERS-1:0]        m_rw;
    logic [NUM_MASTERS*DATA_W-1:0] m_wr_data;
    logic [ADDR_W-1:0]             s_addr;
    logic                          s_as_;
    logic                          s_rw;
    logic [DATA_W-1:0]             s_wr_data;
    logic [NUM_SLAVES-1:0]         s_cs_;
    logic [NUM_SLAVES*DATA_W-1:0]  s_rd_data;
    logic [NUM_SLAVES-1:0]         s_rdy_;
    logic [DATA_W-1:0]             m_rd_data;
    logic                          m_rdy_;
    logic                          bus_err;
    logic [2:0]                    err_master;

    // Interconnect view
    modport slave (
        input  m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
        output m_grnt_, s_addr, s_as_, s_rw, s_wr_data, s_cs_,
               m_rd_data, m_rdy_, bus_err, err_master
    );

    // Environment view: the masters and slaves attached to the bus
    modport master (
        output m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
        input  m_grnt_, s_addr, s_as_, s_rw, s_wr_data, s_cs_,
               m_rd_data, m_rdy_, bus_err, err_master
    );
endinterface
`default_nettype wire

// File: rtl/shared_bus_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shared_bus_rr                                                            |
// | Round-robin arbitrated shared bus with address decode, unmapped-address  |
// | error response and access-timeout watchdog.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shared_bus_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 8,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic           clk,
    input  logic           reset_,
    shared_bus_rr_if.slave bus
);
    localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [MIDX_W-1:0] c_LAST_MASTER = MIDX_W'(NUM_MASTERS - 1);
    localparam logic [WCNT_W-1:0] c_WCNT_LIMIT  = WCNT_W'(TIMEOUT);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_OWNED = 1'b1;

    logic [0:0]             r_state;
    logic [MIDX_W-1:0]      r_owner;
    logic [MIDX_W-1:0]      r_rr;
    logic [NUM_MASTERS-1:0] r_grnt_;
    logic [WCNT_W-1:0]      r_wcnt;
    logic [2:0]             r_errMaster;

    logic                   w_owned;
    logic [NUM_MASTERS-1:0] w_reqActive;
    logic [NUM_MASTERS-1:0] w_cand;
    logic [MIDX_W-1:0]      w_ownerNext;
    logic [MIDX_W-1:0]      w_searchStart;
    logic                   w_hitHi;
    logic                   w_hitAny;
    logic [MIDX_W-1:0]      w_pickHi;
    logic [MIDX_W-1:0]      w_pickAny;
    logic [MIDX_W-1:0]      w_pick;
    logic [NUM_MASTERS-1:0] w_pickOneHot;
    logic                   w_release;

    logic [ADDR_W-1:0]      w_sAddr;
    logic                   w_sAs_;
    logic                   w_sRw;
    logic [DATA_W-1:0]      w_sWrData;
    logic [SEL_W-1:0]       w_sIdx;
    logic [SEL_W-1:0]       w_safeIdx;
    logic                   w_mapped;
    logic [NUM_SLAVES-1:0]  w_cs_;
    logic [DATA_W-1:0]      w_slvData;
    logic                   w_slvRdy_;
    logic                   w_pending;
    logic                   w_timeout;
    logic                   w_unmapped;
    logic                   w_err;
    logic [DATA_W-1:0]      w_rdData;
    logic                   w_rdy_;

    assign w_owned       = (r_state == c_OWNED);
    assign w_reqActive   = ~bus.m_req_;
    assign w_ownerNext   = (r_owner == c_LAST_MASTER) ? '0 : r_owner + 1'b1;
    assign w_searchStart = w_owned ? w_ownerNext : r_rr;
    assign w_release     = w_owned && !w_reqActive[r_owner];

    // Wrapping search: lowest candidate at or above the start index wins,
    // otherwise the lowest candidate overall.
    always_comb begin
        w_cand    = '0;
        w_hitHi   = 1'b0;
        w_hitAny  = 1'b0;
        w_pickHi  = '0;
        w_pickAny = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            w_cand[i] = w_reqActive[i] && !(w_owned && (r_owner == MIDX_W'(i)));
            if (w_cand[i]) begin
                w_hitAny  = 1'b1;
                w_pickAny = MIDX_W'(i);
                if (MIDX_W'(i) >= w_searchStart) begin
                    w_hitHi  = 1'b1;
                    w_pickHi = MIDX_W'(i);
                end
            end
        end
    end

    assign w_pick       = w_hitHi ? w_pickHi : w_pickAny;
    assign w_pickOneHot = NUM_MASTERS'(1) << w_pick;

    always_comb begin
        w_sAddr   = '0;
        w_sAs_    = 1'b1;
        w_sRw     = 1'b1;
        w_sWrData = '0;
        if (w_owned) begin
            w_sAddr   = bus.m_addr[int'(r_owner)*ADDR_W +: ADDR_W];
            w_sAs_    = bus.m_as_[r_owner];
            w_sRw     = bus.m_rw[r_owner];
            w_sWrData = bus.m_wr_data[int'(r_owner)*DATA_W +: DATA_W];
        end
    end

    assign w_sIdx    = w_sAddr[ADDR_W-1 -: SEL_W];
    assign w_mapped  = (int'(w_sIdx) < NUM_SLAVES);
    // Keeps the return-path select in range when the index is unmapped
    assign w_safeIdx = w_mapped ? w_sIdx : '0;
    assign w_slvData = bus.s_rd_data[int'(w_safeIdx)*DATA_W +: DATA_W];
    assign w_slvRdy_ = bus.s_rdy_[w_safeIdx];

    always_comb begin
        w_cs_ = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_owned && w_mapped && (w_sIdx == SEL_W'(i))) begin
                w_cs_[i] = 1'b0;
            end
        end
    end

    // A slave ready in the limit cycle is never pending, so it beats the timeout
    assign w_pending  = w_owned && !w_sAs_ && w_mapped && w_slvRdy_;
    assign w_timeout  = (TIMEOUT != 0) && w_pending && (r_wcnt == c_WCNT_LIMIT);
    assign w_unmapped = w_owned && !w_sAs_ && !w_mapped;
    assign w_err      = w_timeout || w_unmapped;

    always_comb begin
        w_rdData = '0;
        w_rdy_   = 1'b1;
        if (w_err) begin
            w_rdy_ = 1'b0;
        end else if (w_owned && w_mapped) begin
            w_rdData = w_slvData;
            w_rdy_   = w_slvRdy_;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            r_state     <= c_IDLE;
            r_owner     <= '0;
            r_rr        <= '0;
            r_grnt_     <= '1;
            r_wcnt      <= '0;
            r_errMaster <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hitAny) begin
                        r_state <= c_OWNED;
                        r_owner <= w_pick;
                        r_grnt_ <= ~w_pickOneHot;
                    end
                end
                c_OWNED: begin
                    if (w_release) begin
                        r_rr <= w_ownerNext;
                        if (w_hitAny) begin
                            r_owner <= w_pick;
                            r_grnt_ <= ~w_pickOneHot;
                        end else begin
                            r_state <= c_IDLE;
                            r_grnt_ <= '1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grnt_ <= '1;
                end
            endcase

            if ((TIMEOUT == 0) || w_release || !w_pending || w_timeout) begin
                r_wcnt <= '0;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
            end

            if (w_err) begin
                r_errMaster <= 3'(r_owner);
            end
        end
    end

    assign bus.m_grnt_    = r_grnt_;
    assign bus.s_addr     = w_sAddr;
    assign bus.s_as_      = w_sAs_;
    assign bus.s_rw       = w_sRw;
    assign bus.s_wr_data  = w_sWrData;
    assign bus.s_cs_      = w_cs_;
    assign bus.m_rd_data  = w_rdData;
    assign bus.m_rdy_     = w_rdy_;
    assign bus.bus_err    = w_err;
    assign bus.err_master = r_errMaster;
endmodule
`default_nettype wire

// File: tb/tb_shared_bus_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shared_bus_rr                                                         |
// | Directed bench: 8-slave/TIMEOUT=3 bus (A) and 5-slave bus (B).           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_shared_bus_rr;
    logic clk = 1'b0;
    logic reset_;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shared_bus_rr_if #(.NUM_MASTERS(4), .NUM_SLAVES(8), .ADDR_W(30), .DATA_W(32)) busA ();
    shared_bus_rr_if #(.NUM_MASTERS(4), .NUM_SLAVES(5), .ADDR_W(30), .DATA_W(32)) busB ();

    shared_bus_rr #(
        .NUM_MASTERS(4), .NUM_SLAVES(8), .ADDR_W(30), .DATA_W(32), .SEL_W(3), .TIMEOUT(3)
    ) dutA (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (busA.slave)
    );

    shared_bus_rr #(
        .NUM_MASTERS(4), .NUM_SLAVES(5), .ADDR_W(30), .DATA_W(32), .SEL_W(3), .TIMEOUT(3)
    ) dutB (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (busB.slave)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; outputs are checked 1 unit later
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] expG     [10];
    logic [3:0] reqAfter [10];

    initial begin
        expG     = '{4'b1110, 4'b1110, 4'b1110, 4'b1011, 4'b1011,
                     4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b1110};
        reqAfter = '{4'b0010, 4'b0010, 4'b0011, 4'b0010, 4'b0010,
                     4'b0110, 4'b0010, 4'b0010, 4'b1010, 4'b1111};

        reset_ = 1'b1;
        busA.m_req_ = '1; busA.m_as_ = '1; busA.m_rw = '1;
        busA.m_addr = '0; busA.m_wr_data = '0; busA.s_rdy_ = '1;
        busB.m_req_ = '1; busB.m_as_ = '1; busB.m_rw = '1;
        busB.m_addr = '0; busB.m_wr_data = '0; busB.s_rdy_ = '1;
        for (int i = 0; i < 8; i++)
            busA.s_rd_data[i*32 +: 32] = (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + i;
        for (int i = 0; i < 5; i++)
            busB.s_rd_data[i*32 +: 32] = 32'hB000_0000 + i;

        // Reset with every request active
        busA.m_req_ = '0;
        step();
        step();
        #1;
        checkVal("rst_grnt", busA.m_grnt_, 4'b1111);
        checkVal("rst_errm", busA.err_master, 3'd0);
        checkVal("rst_err", busA.bus_err, 1'b0);
        checkVal("rst_cs", busA.s_cs_, 8'hFF);
        checkVal("rst_rdy", busA.m_rdy_, 1'b1);
        checkVal("rst_as", busA.s_as_, 1'b1);
        reset_ = 1'b0;
        step();
        #1;
        checkVal("first_grnt", busA.m_grnt_, 4'b1110);
        checkVal("first_err", busA.bus_err, 1'b0);

        // Round robin among masters 0, 2, 3 from a fresh pointer
        reset_ = 1'b1;
        busA.m_req_ = '1;
        step();
        reset_ = 1'b0;
        busA.m_req_ = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            checkVal($sformatf("rr_grnt%0d", i), busA.m_grnt_, expG[i]);
            busA.m_req_ = reqAfter[i];
        end
        step();
        #1;
        checkVal("rr_idle", busA.m_grnt_, 4'b1111);

        // Read from slave 4 by master 1 (rr pointer now at 1)
        busA.m_addr[30 +: 30] = {3'b100, 27'h0000123};
        busA.m_as_  = 4'b1101;
        busA.m_req_ = 4'b1101;
        step();
        #1;
        checkVal("rd_grnt", busA.m_grnt_, 4'b1101);
        checkVal("rd_cs", busA.s_cs_, 8'b1110_1111);
        checkVal("rd_wait1", busA.m_rdy_, 1'b1);
        step();
        #1;
        checkVal("rd_wait2", busA.m_rdy_, 1'b1);
        step();
        busA.s_rdy_[4] = 1'b0;
        #1;
        checkVal("rd_data", busA.m_rd_data, 32'hDEADBEEF);
        checkVal("rd_rdy", busA.m_rdy_, 1'b0);
        checkVal("rd_err", busA.bus_err, 1'b0);
        busA.m_as_  = '1;
        busA.m_req_ = '1;
        busA.s_rdy_ = '1;
        step();

        // Master 2 reads slave 2, which only answers in cycle 12
        busA.m_addr[60 +: 30] = {3'b010, 27'h0000040};
        busA.m_as_  = 4'b1011;
        busA.m_req_ = 4'b1011;
        for (int c = 1; c <= 12; c++) begin
            logic isErr;
            step();
            busA.s_rdy_[2] = (c == 12) ? 1'b0 : 1'b1;
            #1;
            isErr = (c == 4) || (c == 8);
            if (c == 1) checkVal("to_grnt", busA.m_grnt_, 4'b1011);
            checkVal($sformatf("to_err%0d", c), busA.bus_err, isErr);
            checkVal($sformatf("to_rdy%0d", c), busA.m_rdy_, !(isErr || (c == 12)));
            if (isErr) checkVal($sformatf("to_data%0d", c), busA.m_rd_data, 32'h0);
            if (c == 5) checkVal("to_errm", busA.err_master, 3'd2);
            if (c == 12) checkVal("to_slvwin", busA.m_rd_data, 32'h1000_0002);
        end

        // Reset in the third pending cycle of a fresh access
        for (int c = 13; c <= 15; c++) begin
            step();
            busA.s_rdy_[2] = 1'b1;
            if (c == 15) reset_ = 1'b1;
            #1;
            checkVal($sformatf("mid_err%0d", c), busA.bus_err, 1'b0);
        end
        step();
        reset_ = 1'b0;
        #1;
        checkVal("mid_grnt", busA.m_grnt_, 4'b1111);
        checkVal("mid_as", busA.s_as_, 1'b1);
        checkVal("mid_err", busA.bus_err, 1'b0);
        checkVal("mid_errm", busA.err_master, 3'd0);
        for (int d = 1; d <= 4; d++) begin
            step();
            #1;
            checkVal($sformatf("post_err%0d", d), busA.bus_err, (d == 4));
        end
        busA.m_as_  = '1;
        busA.m_req_ = '1;

        // Unmapped slave index 6 on the 5-slave bus
        busB.m_addr[30 +: 30] = {3'b110, 27'h0000005};
        busB.m_as_  = 4'b1101;
        busB.m_req_ = 4'b1101;
        step();
        #1;
        checkVal("um_grnt", busB.m_grnt_, 4'b1101);
        checkVal("um_rdy", busB.m_rdy_, 1'b0);
        checkVal("um_err", busB.bus_err, 1'b1);
        checkVal("um_cs", busB.s_cs_, 5'b11111);
        checkVal("um_data", busB.m_rd_data, 32'h0);
        step();
        busB.m_as_  = '1;
        busB.m_req_ = '1;
        #1;
        checkVal("um_errm", busB.err_master, 3'd1);
        checkVal("um_clr", busB.bus_err, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
